// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - b_in computed LSB-first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             b_out_q, b_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // Single full-subtractor slice operating on the current LSBs
   logic             x_bit, y_bit, d_bit, borrow_nxt, last_bit;
   logic [WIDTH-1:0] diff_shift;

   assign x_bit      = a_q[0];
   assign y_bit      = b_q[0];
   assign d_bit      = x_bit ^ y_bit ^ borrow_q;
   assign borrow_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_q);
   assign last_bit   = (cnt_q == CNT_W'(WIDTH - 1));

   generate
      if (WIDTH == 1) begin : g_diff_one
         assign diff_shift = d_bit;
      end else begin : g_diff_wide
         assign diff_shift = {d_bit, diff_q[WIDTH-1:1]};
      end
   endgenerate

`ifdef SERIAL_SUB_OVERFLOW_EN
   logic a_msb_q, a_msb_d;
   logic b_msb_q, b_msb_d;
   logic ovf_q, ovf_d;
`endif

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      b_out_d  = b_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               borrow_d = b_in;
               cnt_d    = '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
               a_msb_d  = a[WIDTH-1];
               b_msb_d  = b[WIDTH-1];
`endif
               state_d  = SHIFT;
            end else begin
               state_d  = IDLE;
            end
         end
         SHIFT: begin
            borrow_d = borrow_nxt;
            diff_d   = diff_shift;
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (last_bit) begin
               state_d = DONE;
               b_out_d = borrow_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
               // d_bit is the result MSB on the final shift cycle
               ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         b_out_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         b_out_q  <= b_out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign diff  = diff_q;
   assign b_out = b_out_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Overflow checks are included when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       start8, bin8, busy8, done8, bout8;
   logic [7:0] a8, b8, diff8;
   logic       start1, bin1, busy1, done1, bout1;
   logic [0:0] a1, b1, diff1;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic       ovf8, ovf1;
`endif

   serial_subtractor #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .b_in(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .b_out(bout8)
`ifdef SERIAL_SUB_OVERFLOW_EN
      , .ovf(ovf8)
`endif
   );

   serial_subtractor #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .b_in(bin1),
      .busy(busy1), .done(done1), .diff(diff1), .b_out(bout1)
`ifdef SERIAL_SUB_OVERFLOW_EN
      , .ovf(ovf1)
`endif
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
      int         due;
   } exp_t;

   exp_t q8[$];
   exp_t q1[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on w-bit operands
   function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                  input logic bin, input int due);
      exp_t e;
      int   mask, ua, ub, full, sa, sb, sres;
      mask   = (1 << w) - 1;
      ua     = int'(a) & mask;
      ub     = int'(b) & mask;
      full   = ua - ub - int'(bin);
      sa     = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
      sb     = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
      sres   = sa - sb - int'(bin);
      e.a    = a;
      e.b    = b;
      e.bin  = bin;
      e.diff = 8'(full & mask);
      e.bout = (full < 0);
      e.ovf  = (sres > (1 << (w - 1)) - 1) || (sres < -(1 << (w - 1)));
      e.due  = due;
      return e;
   endfunction

   always @(negedge clk) begin : mon8
      exp_t e;
      if (!rst) begin
         if (done8) begin
            if (q8.size() == 0) begin
               chk("w8_unexpected_done", 32'(done8), 32'(0));
            end else begin
               e = q8.pop_front();
               $display("txn w8 a=%h b=%h b_in=%0d diff=%h b_out=%0d cycle=%0d",
                        e.a, e.b, e.bin, diff8, bout8, cyc);
               chk("w8_diff", 32'(diff8), 32'(e.diff));
               chk("w8_b_out", 32'(bout8), 32'(e.bout));
               chk("w8_latency", 32'(cyc), 32'(e.due));
               chk("w8_busy_in_done", 32'(busy8), 32'(0));
`ifdef SERIAL_SUB_OVERFLOW_EN
               chk("w8_ovf", 32'(ovf8), 32'(e.ovf));
`endif
            end
         end else if (q8.size() > 0 && cyc > q8[0].due) begin
            chk("w8_done_missing", 32'(0), 32'(1));
            e = q8.pop_front();
         end
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (!rst) begin
         if (done1) begin
            if (q1.size() == 0) begin
               chk("w1_unexpected_done", 32'(done1), 32'(0));
            end else begin
               e = q1.pop_front();
               $display("txn w1 a=%0d b=%0d b_in=%0d diff=%0d b_out=%0d cycle=%0d",
                        e.a[0], e.b[0], e.bin, diff1, bout1, cyc);
               chk("w1_diff", 32'(diff1), 32'(e.diff));
               chk("w1_b_out", 32'(bout1), 32'(e.bout));
               chk("w1_latency", 32'(cyc), 32'(e.due));
               chk("w1_busy_in_done", 32'(busy1), 32'(0));
`ifdef SERIAL_SUB_OVERFLOW_EN
               chk("w1_ovf", 32'(ovf1), 32'(e.ovf));
`endif
            end
         end else if (q1.size() > 0 && cyc > q1[0].due) begin
            chk("w1_done_missing", 32'(0), 32'(1));
            e = q1.pop_front();
         end
      end
   end

   // All drive tasks are entered and left on a falling edge
   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin);
      start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
      q8.push_back(model(8, a, b, bin, cyc + 1 + 8));
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      chk("w8_busy_after_start", 32'(busy8), 32'(1));
   endtask

   task automatic drive1(input logic a, input logic b, input logic bin);
      start1 = 1'b1; a1 = a; b1 = b; bin1 = bin;
      q1.push_back(model(1, {7'd0, a}, {7'd0, b}, bin, cyc + 1 + 1));
      @(negedge clk);
      start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); bin1 = 1'($urandom);
      chk("w1_busy_after_start", 32'(busy1), 32'(1));
   endtask

   task automatic wait8();
      int n = 0;
      while (q8.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (q8.size() != 0) begin
         chk("w8_wait_timeout", 32'(0), 32'(1));
         q8.delete();
      end
   endtask

   task automatic wait1();
      int n = 0;
      while (q1.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (q1.size() != 0) begin
         chk("w1_wait_timeout", 32'(0), 32'(1));
         q1.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int         due;
      int         mode;
      logic [2:0] k;
      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_w8_busy", 32'(busy8), 32'(0));
      chk("rst_w8_done", 32'(done8), 32'(0));
      chk("rst_w8_diff", 32'(diff8), 32'(0));
      chk("rst_w8_b_out", 32'(bout8), 32'(0));
      chk("rst_w1_busy", 32'(busy1), 32'(0));
      chk("rst_w1_done", 32'(done1), 32'(0));
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk("rst_w8_ovf", 32'(ovf8), 32'(0));
`endif
      rst = 1'b0;
      @(negedge clk);

      drive8(8'h5A, 8'h3C, 1'b0); wait8();
      drive8(8'h00, 8'h01, 1'b0); wait8();
      drive8(8'h10, 8'h0F, 1'b1); wait8();
      drive8(8'h80, 8'h01, 1'b0); wait8();
      drive8(8'h05, 8'h03, 1'b0); wait8();

      // A start three cycles into SHIFT must be ignored
      drive8(8'hC3, 8'h5A, 1'b1);
      repeat (2) @(negedge clk);
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      wait8();
      repeat (2) @(negedge clk);

      // Asynchronous reset four cycles into SHIFT
      drive8(8'h5A, 8'h3C, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_w8_busy", 32'(busy8), 32'(0));
      chk("midrst_w8_done", 32'(done8), 32'(0));
      chk("midrst_w8_diff", 32'(diff8), 32'(0));
      chk("midrst_w8_b_out", 32'(bout8), 32'(0));
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk("midrst_w8_ovf", 32'(ovf8), 32'(0));
`endif
      q8.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      drive8(8'h5A, 8'h3C, 1'b0); wait8();

      // Back-to-back: start raised in the done cycle
      drive8(8'hA7, 8'h3B, 1'b1);
      due = q8[q8.size() - 1].due;
      while (cyc < due) @(negedge clk);
      drive8(8'h01, 8'hFE, 1'b0);
      wait8();

      for (int i = 0; i < 40; i++) begin
         mode = int'($urandom_range(0, 2));
         if (mode == 0 && q8.size() > 0) begin
            due = q8[q8.size() - 1].due;
            while (cyc < due) @(negedge clk);
         end else begin
            wait8();
            repeat (mode) @(negedge clk);
         end
         drive8(8'($urandom), 8'($urandom), 1'($urandom));
      end
      wait8();

      for (int i = 0; i < 8; i++) begin
         k = 3'(i);
         drive1(k[2], k[1], k[0]);
         wait1();
      end
      for (int i = 0; i < 12; i++) begin
         if (q1.size() > 0) begin
            due = q1[q1.size() - 1].due;
            while (cyc < due) @(negedge clk);
         end
         drive1(1'($urandom), 1'($urandom), 1'($urandom));
      end
      wait1();
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
